// File: rtl/hazard_ctrl_pipe_if.sv
// Signal bundle between the decoder-side D stage and hazard_ctrl_pipe: D-stage
// controls in; E/M/W pipe controls, forwarding selects and stall/flush out.
interface hazard_ctrl_pipe_if #(
    parameter int REGW  = 5,
    parameter int ALUCW = 3
);
    logic             regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d;
    logic [ALUCW-1:0] alucontrol_d;
    logic [REGW-1:0]  rs_d, rt_d, rd_d;

    logic             regwrite_e, memtoreg_e, memwrite_e, alusrc_e;
    logic [ALUCW-1:0] alucontrol_e;
    logic [REGW-1:0]  rs_e, rt_e, writereg_e;
    logic             regwrite_m, memtoreg_m, memwrite_m;
    logic [REGW-1:0]  writereg_m;
    logic             regwrite_w, memtoreg_w;
    logic [REGW-1:0]  writereg_w;

    logic [1:0]       forward_ae, forward_be;
    logic             forward_ad, forward_bd;
    logic             stall_f, stall_d, flush_e;

    modport master (
        output regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d,
               alucontrol_d, rs_d, rt_d, rd_d,
        input  regwrite_e, memtoreg_e, memwrite_e, alusrc_e, alucontrol_e,
               rs_e, rt_e, writereg_e, regwrite_m, memtoreg_m, memwrite_m, writereg_m,
               regwrite_w, memtoreg_w, writereg_w, forward_ae, forward_be,
               forward_ad, forward_bd, stall_f, stall_d, flush_e
    );

    modport slave (
        input  regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d,
               alucontrol_d, rs_d, rt_d, rd_d,
        output regwrite_e, memtoreg_e, memwrite_e, alusrc_e, alucontrol_e,
               rs_e, rt_e, writereg_e, regwrite_m, memtoreg_m, memwrite_m, writereg_m,
               regwrite_w, memtoreg_w, writereg_w, forward_ae, forward_be,
               forward_ad, forward_bd, stall_f, stall_d, flush_e
    );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// MIPS control pipe (D->E->M->W) with data-hazard stall/flush and forwarding.
// HAZARD_FORWARD_EN selects forwarding; undefined means stall-only resolution.
module hazard_ctrl_pipe #(
    parameter int REGW  = 5,
    parameter int ALUCW = 3
) (
    input  logic                clk,
    input  logic                reset,
    hazard_ctrl_pipe_if.slave   bus
);
    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             alusrc;
        logic             regdst;
        logic [ALUCW-1:0] alucontrol;
        logic [REGW-1:0]  rs;
        logic [REGW-1:0]  rt;
        logic [REGW-1:0]  rd;
    } de_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic [REGW-1:0]  writereg;
    } em_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic [REGW-1:0]  writereg;
    } mw_t;

    de_t de_q, de_d;
    em_t em_q, em_d;
    mw_t mw_q, mw_d;

    logic [REGW-1:0] writereg_e;
    logic            hazard;
    logic [1:0]      fwd_ae, fwd_be;
    logic            fwd_ad, fwd_bd;

    function automatic logic src_match(input logic [REGW-1:0] s,
                                       input logic [REGW-1:0] wr,
                                       input logic            rw);
        return (s != '0) && (s == wr) && rw;
    endfunction

    assign writereg_e = de_q.regdst ? de_q.rd : de_q.rt;

    always_comb begin
        de_d = '0;
        if (!hazard) begin
            de_d.regwrite   = bus.regwrite_d;
            de_d.memtoreg   = bus.memtoreg_d;
            de_d.memwrite   = bus.memwrite_d;
            de_d.alusrc     = bus.alusrc_d;
            de_d.regdst     = bus.regdst_d;
            de_d.alucontrol = bus.alucontrol_d;
            de_d.rs         = bus.rs_d;
            de_d.rt         = bus.rt_d;
            de_d.rd         = bus.rd_d;
        end
        em_d.regwrite = de_q.regwrite;
        em_d.memtoreg = de_q.memtoreg;
        em_d.memwrite = de_q.memwrite;
        em_d.writereg = writereg_e;
        mw_d.regwrite = em_q.regwrite;
        mw_d.memtoreg = em_q.memtoreg;
        mw_d.writereg = em_q.writereg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de_q <= '0;
            em_q <= '0;
            mw_q <= '0;
        end else begin
            de_q <= de_d;
            em_q <= em_d;
            mw_q <= mw_d;
        end
    end

`ifdef HAZARD_FORWARD_EN
    logic lwstall, brstall;

    always_comb begin
        fwd_ae = 2'b00;
        fwd_be = 2'b00;
        if (src_match(de_q.rs, em_q.writereg, em_q.regwrite))      fwd_ae = 2'b10;
        else if (src_match(de_q.rs, mw_q.writereg, mw_q.regwrite)) fwd_ae = 2'b01;
        if (src_match(de_q.rt, em_q.writereg, em_q.regwrite))      fwd_be = 2'b10;
        else if (src_match(de_q.rt, mw_q.writereg, mw_q.regwrite)) fwd_be = 2'b01;
        fwd_ad = src_match(bus.rs_d, em_q.writereg, em_q.regwrite);
        fwd_bd = src_match(bus.rt_d, em_q.writereg, em_q.regwrite);

        // rt_d is compared even when it is an I-type destination: a safe over-stall.
        lwstall = de_q.memtoreg && (writereg_e != '0) &&
                  ((writereg_e == bus.rs_d) || (writereg_e == bus.rt_d));
        brstall = bus.branch_d &&
                  (src_match(bus.rs_d, writereg_e, de_q.regwrite) ||
                   src_match(bus.rt_d, writereg_e, de_q.regwrite) ||
                   (em_q.memtoreg &&
                    (src_match(bus.rs_d, em_q.writereg, em_q.regwrite) ||
                     src_match(bus.rt_d, em_q.writereg, em_q.regwrite))));
        hazard = lwstall || brstall;
    end
`else
    // Without forwarding any RAW on E or M stalls; W is covered by the
    // register file's write-first/read-second half-cycle split.
    always_comb begin
        fwd_ae = 2'b00;
        fwd_be = 2'b00;
        fwd_ad = 1'b0;
        fwd_bd = 1'b0;
        hazard = (bus.branch_d || !bus.branch_d) &&
                 (src_match(bus.rs_d, writereg_e, de_q.regwrite) ||
                  src_match(bus.rt_d, writereg_e, de_q.regwrite) ||
                  src_match(bus.rs_d, em_q.writereg, em_q.regwrite) ||
                  src_match(bus.rt_d, em_q.writereg, em_q.regwrite));
    end
`endif

    assign bus.regwrite_e   = de_q.regwrite;
    assign bus.memtoreg_e   = de_q.memtoreg;
    assign bus.memwrite_e   = de_q.memwrite;
    assign bus.alusrc_e     = de_q.alusrc;
    assign bus.alucontrol_e = de_q.alucontrol;
    assign bus.rs_e         = de_q.rs;
    assign bus.rt_e         = de_q.rt;
    assign bus.writereg_e   = writereg_e;
    assign bus.regwrite_m   = em_q.regwrite;
    assign bus.memtoreg_m   = em_q.memtoreg;
    assign bus.memwrite_m   = em_q.memwrite;
    assign bus.writereg_m   = em_q.writereg;
    assign bus.regwrite_w   = mw_q.regwrite;
    assign bus.memtoreg_w   = mw_q.memtoreg;
    assign bus.writereg_w   = mw_q.writereg;
    assign bus.forward_ae   = fwd_ae;
    assign bus.forward_be   = fwd_be;
    assign bus.forward_ad   = fwd_ad;
    assign bus.forward_bd   = fwd_bd;
    assign bus.stall_f      = hazard;
    assign bus.stall_d      = hazard;
    assign bus.flush_e      = hazard;
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: instruction-level pipeline model, per-cycle
// compare, directed hazard scenarios and randomized instruction streams.
module tb_hazard_ctrl_pipe;
    typedef struct packed {
        logic       regwrite, memtoreg, memwrite, alusrc, regdst, branch;
        logic [2:0] aluc;
        logic [4:0] rs, rt, rd;
    } instr_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    instr_t d = '0;
    instr_t e_q = '0, m_q = '0, w_q = '0;
    logic   last_stall = 1'b0;
    logic   cmp_en = 1'b0;
    int     n_pass = 0, n_total = 0;

    hazard_ctrl_pipe_if #(.REGW(5), .ALUCW(3)) bus ();

    hazard_ctrl_pipe #(.REGW(5), .ALUCW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.regwrite_d   = d.regwrite;
    assign bus.memtoreg_d   = d.memtoreg;
    assign bus.memwrite_d   = d.memwrite;
    assign bus.alusrc_d     = d.alusrc;
    assign bus.regdst_d     = d.regdst;
    assign bus.branch_d     = d.branch;
    assign bus.alucontrol_d = d.aluc;
    assign bus.rs_d         = d.rs;
    assign bus.rt_d         = d.rt;
    assign bus.rd_d         = d.rd;

    always #5 clk = ~clk;

    // ---- instruction builders ----
    function automatic instr_t f_nop();
        return '0;
    endfunction
    function automatic instr_t f_add(input logic [4:0] rd, rs, rt);
        instr_t i = '0;
        i.regwrite = 1'b1; i.regdst = 1'b1; i.aluc = 3'b010;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction
    function automatic instr_t f_lw(input logic [4:0] rt, rs);
        instr_t i = '0;
        i.regwrite = 1'b1; i.memtoreg = 1'b1; i.alusrc = 1'b1; i.aluc = 3'b010;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction
    function automatic instr_t f_beq(input logic [4:0] rs, rt);
        instr_t i = '0;
        i.branch = 1'b1; i.aluc = 3'b110; i.rs = rs; i.rt = rt;
        return i;
    endfunction
    function automatic instr_t rand_instr();
        instr_t i;
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        c = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: i = f_nop();
            1: i = f_add(a, b, c);
            2: i = f_lw(a, b);
            3: begin i = f_lw(a, b); i.regwrite = 1'b0; i.memtoreg = 1'b0; i.memwrite = 1'b1; end
            4: i = f_beq(a, b);
            default: begin i = f_lw(a, b); i.memtoreg = 1'b0; i.aluc = 3'($urandom_range(0, 7)); end
        endcase
        return i;
    endfunction

    // ---- behavioural model: instructions flow through E, M, W slots ----
    function automatic logic [4:0] dest(input instr_t i);
        return i.regdst ? i.rd : i.rt;
    endfunction
    function automatic logic writes(input logic [4:0] s, input instr_t i);
        return (s != 5'd0) && i.regwrite && (dest(i) == s);
    endfunction
    function automatic logic model_stall(input instr_t e, m, di);
`ifdef HAZARD_FORWARD_EN
        logic lw_hz, br_hz;
        lw_hz = e.memtoreg && (dest(e) != 5'd0) && (dest(e) == di.rs || dest(e) == di.rt);
        br_hz = di.branch && (writes(di.rs, e) || writes(di.rt, e) ||
                              (m.memtoreg && (writes(di.rs, m) || writes(di.rt, m))));
        return lw_hz || br_hz;
`else
        return writes(di.rs, e) || writes(di.rt, e) || writes(di.rs, m) || writes(di.rt, m);
`endif
    endfunction
    function automatic logic [1:0] model_fwd(input logic [4:0] s, input instr_t m, w);
`ifdef HAZARD_FORWARD_EN
        if (writes(s, m)) return 2'b10;
        if (writes(s, w)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            e_q <= '0; m_q <= '0; w_q <= '0; last_stall <= 1'b0;
        end else begin
            last_stall <= model_stall(e_q, m_q, d);
            e_q <= model_stall(e_q, m_q, d) ? '0 : d;
            m_q <= e_q;
            w_q <= m_q;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // ---- per-cycle compare against the model ----
    always @(negedge clk) begin
        if (cmp_en) begin
            logic st;
            st = model_stall(e_q, m_q, d);
            chk("regwrite_e", 8'(bus.regwrite_e), 8'(e_q.regwrite));
            chk("memtoreg_e", 8'(bus.memtoreg_e), 8'(e_q.memtoreg));
            chk("memwrite_e", 8'(bus.memwrite_e), 8'(e_q.memwrite));
            chk("alusrc_e", 8'(bus.alusrc_e), 8'(e_q.alusrc));
            chk("alucontrol_e", 8'(bus.alucontrol_e), 8'(e_q.aluc));
            chk("rs_e", 8'(bus.rs_e), 8'(e_q.rs));
            chk("rt_e", 8'(bus.rt_e), 8'(e_q.rt));
            chk("writereg_e", 8'(bus.writereg_e), 8'(dest(e_q)));
            chk("regwrite_m", 8'(bus.regwrite_m), 8'(m_q.regwrite));
            chk("memtoreg_m", 8'(bus.memtoreg_m), 8'(m_q.memtoreg));
            chk("memwrite_m", 8'(bus.memwrite_m), 8'(m_q.memwrite));
            chk("writereg_m", 8'(bus.writereg_m), 8'(dest(m_q)));
            chk("regwrite_w", 8'(bus.regwrite_w), 8'(w_q.regwrite));
            chk("memtoreg_w", 8'(bus.memtoreg_w), 8'(w_q.memtoreg));
            chk("writereg_w", 8'(bus.writereg_w), 8'(dest(w_q)));
            chk("forward_ae", 8'(bus.forward_ae), 8'(model_fwd(e_q.rs, m_q, w_q)));
            chk("forward_be", 8'(bus.forward_be), 8'(model_fwd(e_q.rt, m_q, w_q)));
            chk("forward_ad", 8'(bus.forward_ad), 8'(model_fwd(d.rs, m_q, m_q) == 2'b10));
            chk("forward_bd", 8'(bus.forward_bd), 8'(model_fwd(d.rt, m_q, m_q) == 2'b10));
            chk("stall_f", 8'(bus.stall_f), 8'(st));
            chk("stall_d", 8'(bus.stall_d), 8'(st));
            chk("flush_e", 8'(bus.flush_e), 8'(st));
        end
    end

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask
    task automatic drain();
        d = f_nop();
        repeat (3) tick();
    endtask
    task automatic lit_stall(input string name, input logic exp);
        at_neg();
        chk({name, "_stall_f"}, 8'(bus.stall_f), 8'(exp));
        chk({name, "_flush_e"}, 8'(bus.flush_e), 8'(exp));
    endtask

    initial begin
        reset = 1'b1;
        d = f_nop();
        repeat (2) tick();
        reset = 1'b0;
        cmp_en = 1'b1;

        at_neg();
        chk("rst_regwrite_e", 8'(bus.regwrite_e), 8'd0);
        chk("rst_writereg_m", 8'(bus.writereg_m), 8'd0);
        chk("rst_regwrite_w", 8'(bus.regwrite_w), 8'd0);
        chk("rst_forward_ae", 8'(bus.forward_ae), 8'd0);
        chk("rst_stall_f", 8'(bus.stall_f), 8'd0);

        // $0 never forwards or stalls
        tick();
        d = f_add(5'd0, 5'd1, 5'd2); tick();
        d = f_add(5'd3, 5'd0, 5'd0);
        lit_stall("zero_d", 1'b0);
        tick(); d = f_nop();
        at_neg();
        chk("zero_fwd_ae", 8'(bus.forward_ae), 8'd0);
        chk("zero_fwd_be", 8'(bus.forward_be), 8'd0);
        tick(); drain();

`ifdef HAZARD_FORWARD_EN
        // load-use: one stall, then W forwarding
        d = f_lw(5'd8, 5'd0); tick();
        d = f_add(5'd9, 5'd8, 5'd8);
        lit_stall("lwuse1", 1'b1);
        tick();
        lit_stall("lwuse2", 1'b0);
        tick(); d = f_nop();
        at_neg();
        chk("lwuse_fwd_ae", 8'(bus.forward_ae), 8'd1);
        chk("lwuse_fwd_be", 8'(bus.forward_be), 8'd1);
        tick(); drain();

        // M has priority over W
        d = f_add(5'd8, 5'd1, 5'd2); tick();
        d = f_add(5'd8, 5'd3, 5'd4); tick();
        d = f_add(5'd10, 5'd8, 5'd8); tick();
        d = f_nop();
        at_neg();
        chk("mprio_fwd_ae", 8'(bus.forward_ae), 8'd2);
        chk("mprio_fwd_be", 8'(bus.forward_be), 8'd2);
        tick(); drain();

        // branch after load: two stalls, then value from W path
        d = f_lw(5'd8, 5'd0); tick();
        d = f_beq(5'd8, 5'd9);
        lit_stall("brlw1", 1'b1); tick();
        lit_stall("brlw2", 1'b1); tick();
        lit_stall("brlw3", 1'b0);
        chk("brlw_fwd_ad", 8'(bus.forward_ad), 8'd0);
        tick(); drain();

        // branch after ALU op: one stall, then M forwarding
        d = f_add(5'd8, 5'd1, 5'd2); tick();
        d = f_beq(5'd8, 5'd9);
        lit_stall("bralu1", 1'b1); tick();
        lit_stall("bralu2", 1'b0);
        chk("bralu_fwd_ad", 8'(bus.forward_ad), 8'd1);
        tick(); drain();

        // reset during a load-use stall
        d = f_lw(5'd8, 5'd0); tick();
        d = f_add(5'd9, 5'd8, 5'd8);
        lit_stall("rststall1", 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        at_neg();
        chk("rststall_regwrite_e", 8'(bus.regwrite_e), 8'd0);
        chk("rststall_memtoreg_m", 8'(bus.memtoreg_m), 8'd0);
        chk("rststall_stall_f", 8'(bus.stall_f), 8'd0);
        tick();
        lit_stall("rststall2", 1'b0);
        tick(); drain();
`else
        // RAW at distance 1 stalls two cycles
        d = f_add(5'd8, 5'd1, 5'd2); tick();
        d = f_add(5'd9, 5'd8, 5'd1);
        lit_stall("dist1_a", 1'b1);
        chk("dist1_fwd_ae", 8'(bus.forward_ae), 8'd0);
        tick();
        lit_stall("dist1_b", 1'b1); tick();
        lit_stall("dist1_c", 1'b0);
        tick(); drain();

        // RAW at distance 2 stalls one cycle
        d = f_add(5'd8, 5'd1, 5'd2); tick();
        d = f_nop(); tick();
        d = f_add(5'd9, 5'd8, 5'd1);
        lit_stall("dist2_a", 1'b1); tick();
        lit_stall("dist2_b", 1'b0);
        tick(); drain();

        // reset clears a pending stall
        d = f_add(5'd8, 5'd1, 5'd2); tick();
        d = f_add(5'd9, 5'd8, 5'd8);
        lit_stall("rststall1", 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        lit_stall("rststall2", 1'b0);
        chk("rststall_regwrite_e", 8'(bus.regwrite_e), 8'd0);
        tick(); drain();
`endif

        // randomized instruction stream; F/D holds while stalled
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 79) == 0) reset = 1'b1;
            else reset = 1'b0;
            if (!last_stall || reset) d = rand_instr();
            tick();
        end
        reset = 1'b0;
        drain();
        at_neg();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_pipe.md
# hazard_ctrl_pipe

- Carries the decoded control word of the pipelined MIPS core through the execute (E), memory (M) and writeback (W) pipeline registers.
- Resolves the E-stage destination register.
- Generates all data-hazard controls: load-use and branch stalls, the E-stage flush, and forwarding selects for the E and D stages.
- Sits directly downstream of the instruction decoder/controller.
- Feeds the datapath's E/M/W multiplexers and the F/D pipeline-register enables.

## Interface
Parameters:
- `REGW`, default 5: register-specifier width.
- `ALUCW`, default 3: alucontrol width.

Ports:
- `clk  in  1`: the single core clock.
- `reset  in  1`: synchronous, active-high reset.
- `regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, branch_d  in  1 each`: decoder outputs for the D-stage instruction.
- `alucontrol_d  in  ALUCW`: decoder ALU control.
- `rs_d, rt_d, rd_d  in  REGW`: D-stage instruction fields.
- `regwrite_e, memtoreg_e, memwrite_e, alusrc_e  out  1`: E-stage control.
- `alucontrol_e  out  ALUCW`: E-stage ALU control.
- `rs_e, rt_e, writereg_e  out  REGW`: E-stage specifiers; `writereg_e = regdst_e ? rd_e : rt_e`.
- `regwrite_m, memtoreg_m, memwrite_m  out  1`; `writereg_m  out  REGW`: M-stage signals.
- `regwrite_w, memtoreg_w  out  1`; `writereg_w  out  REGW`: W-stage signals.
- `forward_ae, forward_be  out  2`: E-stage operand select.
  - 00 = register file.
  - 01 = W result.
  - 10 = M ALU result.
- `forward_ad, forward_bd  out  1`: D-stage branch comparator operand select; 1 = M ALU result.
- `stall_f, stall_d  out  1`: hold the PC and the F/D register.
- `flush_e  out  1`: clear the datapath's D/E register.

## Operation
Pipe registers:
- D→E, E→M and M→W copy the relevant controls and specifiers every cycle; there is no enable.
- When `flush_e` = 1, the D→E register loads all-zero at the next edge, which is a bubble.
- E→M and M→W are never stalled or flushed.

Matching:
- A "match" of source `s` against stage X requires `s != 0`, `s == writereg_x` and `regwrite_x == 1`.
- `rt_d` is always compared, even for I-type instructions where `rt` is the destination; this conservative stall is intended.

Forwarding (macro defined):
- `forward_ae` is 10 if `rs_e` matches M, else 01 if `rs_e` matches W, else 00. M has priority over W.
- `forward_be` is the same, applied to `rt_e`.
- `forward_ad` = `rs_d` matches M; `forward_bd` = `rt_d` matches M.

Stalls:
- `lwstall = memtoreg_e & (writereg_e != 0) & (writereg_e == rs_d | writereg_e == rt_d)`.
- `brstall = branch_d & ((rs_d or rt_d matches E) | (memtoreg_m & (rs_d or rt_d matches M)))`.
- `stall_f = stall_d = flush_e = lwstall | brstall`.
- Register $0 never forwards and never causes a stall.

## Timing
- All hazard outputs are combinational from current pipe state and D-stage inputs, valid in the same cycle.
- D-stage control appears at the E outputs 1 cycle after the edge, at M after 2 cycles and at W after 3 cycles.
- A load-use hazard costs exactly 1 stall cycle.
- A branch depending on an E-stage ALU op costs 1 stall cycle.
- A branch depending on an E-stage load costs 2 stall cycles.
- Reset:
  - Every pipe register is cleared at the next rising edge, so every registered output is 0.
  - With all pipe registers zero, every hazard output is 0.
  - Reset during a stall clears the bubble state; there is no residual stall after reset deasserts.
- Simultaneous stall and M/W hazards: forwarding selects remain valid for the E instruction while D stalls.

## Configuration
- `HAZARD_FORWARD_EN` defined: forwarding and stalls as above.
- `HAZARD_FORWARD_EN` undefined:
  - All `forward_*` outputs are tied to 0.
  - `stall_f = stall_d = flush_e = branch_d | !branch_d` qualified by the hazard condition: (`rs_d` or `rt_d` matches E) | (`rs_d` or `rt_d` matches M).
  - W needs no stall because the register file writes in the first half-cycle and reads in the second.
  - A RAW dependency at distance 1 stalls 2 cycles; at distance 2 it stalls 1 cycle.

## Test plan
- Load-use: `lw $8,0($0)` then `add $9,$8,$8` → exactly one cycle of `stall_f`/`stall_d`/`flush_e` = 1; next cycle `forward_ae` = `forward_be` = 01.
- M and W forwarding: `add $8`; `add $8`; `sub $10,$8,$8` → sub in E sees `forward_ae` = 10, confirming M priority over W.
- Register $0: `add $0,$1,$2`; `add $3,$0,$0` → `forward_ae` = `forward_be` = 00 and no stall.
- Branch after load: `lw $8`; `beq $8,$9` → 2 stall cycles, then `forward_ad` = 0 with the value taken from the W path.
  - Branch after ALU op: `add $8`; `beq $8,$9` → 1 stall cycle, then `forward_ad` = 1.
- Reset mid-stall: assert `reset` during the `lwstall` cycle → next cycle all outputs are 0; after deassert the pipe refills with no stall.
- With `HAZARD_FORWARD_EN` undefined: `add $8`; `sub $9,$8,$1` → 2 stall cycles and all forward selects 0.
